// File: rtl/mmmain_core_if.sv
// mmmain_core_if
//   Board-facing bundle for the matrix-multiply engine.
//   sel : LED view select (driven by the board / bench)
//   led : 16-bit display bus (driven by the engine)
//   Modports: master drives sel and observes led; slave is the engine side.
interface mmmain_core_if;
  logic        sel;
  logic [15:0] led;

  modport master (output sel, input  led);
  modport slave  (input  sel, output led);
endinterface

// File: rtl/mmmain_core.sv
// mmmain_core
//   4x4 unsigned 8-bit matrix-multiply engine, C = A x B, with A and B taken
//   from fixed on-chip tables (A[i][j] = 4i + j + 1, B = A). One
//   multiply-accumulate per clock; keeps the 16 x 18-bit result matrix, a
//   running 24-bit checksum and, optionally, the trace.
//
//   Ports:
//     clk : system clock
//     rst : synchronous, active-high reset
//     bus : mmmain_core_if.slave -- sel in, led out
//
//   Build option:
//     MMMAIN_TRACE_EN  when defined, the trace register exists and sel=1
//                      shows trace[15:0] once done (0 before). When undefined,
//                      sel=1 shows {done, 0, state, 4'b0, checksum[23:16]}.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | one cycle after reset, then start computing
//   COMPUTE | 64 MAC cycles walking i (outer), j, k (inner)
//   DONE    | result, checksum and trace frozen until reset; done = 1
module mmmain_core (
  input  logic         clk,
  input  logic         rst,
  mmmain_core_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_COMPUTE = 2'b01,
    ST_DONE    = 2'b10
  } state_t;

  state_t      state_q;
  logic        done_q;
  logic [1:0]  i_q, j_q, k_q;
  logic [17:0] acc_q;
  logic [23:0] checksum_q;
  logic [17:0] c_q [16];
`ifdef MMMAIN_TRACE_EN
  logic [23:0] trace_q;
`endif

  logic [7:0]  a_elem_d;
  logic [7:0]  b_elem_d;
  logic [15:0] prod_d;
  logic [17:0] mac_d;
  logic [15:0] led_d;

  // Table entry at (row, col) is 4*row + col + 1, i.e. {row, col} + 1.
  function automatic logic [7:0] rom_elem(input logic [1:0] row, input logic [1:0] col);
    return {4'b0000, row, col} + 8'd1;
  endfunction

  always_comb begin
    a_elem_d = rom_elem(i_q, k_q);
    b_elem_d = rom_elem(k_q, j_q);
    prod_d   = a_elem_d * b_elem_d;
    mac_d    = acc_q + {2'b00, prod_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      done_q     <= 1'b0;
      i_q        <= 2'd0;
      j_q        <= 2'd0;
      k_q        <= 2'd0;
      acc_q      <= '0;
      checksum_q <= '0;
      for (int n = 0; n < 16; n++) begin
        c_q[n] <= '0;
      end
`ifdef MMMAIN_TRACE_EN
      trace_q    <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q <= ST_COMPUTE;
        end
        ST_COMPUTE: begin
          k_q <= k_q + 2'd1;
          if (k_q == 2'd3) begin
            // Last term of the dot product: commit the element and fold it
            // into the running sums; acc restarts for the next element.
            c_q[{i_q, j_q}] <= mac_d;
            checksum_q      <= checksum_q + {6'b0, mac_d};
            acc_q           <= '0;
`ifdef MMMAIN_TRACE_EN
            if (i_q == j_q) begin
              trace_q <= trace_q + {6'b0, mac_d};
            end
`endif
            j_q <= j_q + 2'd1;
            if (j_q == 2'd3) begin
              i_q <= i_q + 2'd1;
              if (i_q == 2'd3) begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
              end
            end
          end else begin
            acc_q <= mac_d;
          end
        end
        ST_DONE: begin
          done_q <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Select path is deliberately unregistered so led follows sel immediately.
  always_comb begin
    led_d = checksum_q[15:0];
    if (bus.sel) begin
`ifdef MMMAIN_TRACE_EN
      led_d = done_q ? trace_q[15:0] : 16'h0000;
`else
      led_d = {done_q, 1'b0, state_q, 4'b0000, checksum_q[23:16]};
`endif
    end
  end

  assign bus.led = led_d;

endmodule

// File: tb/tb_mmmain_core.sv
module tb_mmmain_core;

  logic clk;
  logic rst;
  int   vectors;
  int   errors;
  int   edge_n;

  mmmain_core_if bus ();

  mmmain_core dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic tick(input int n);
    for (int t = 0; t < n; t++) begin
      @(posedge clk);
      edge_n++;
    end
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at edge %0d: observed=0x%0h expected=0x%0h", tag, edge_n, obs, exp);
    end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    edge_n  = 0;
    rst     = 1'b1;
    bus.sel = 1'b0;

    // Reset held for 5 cycles.
    tick(5);
    check("reset_led", 32'(bus.led), 32'h0000);
    check("reset_state", 32'(dut.state_q), 32'd0);
    check("reset_c00", 32'(dut.c_q[0]), 32'd0);

    // Release: the edge just taken is edge 0.
    rst    = 1'b0;
    edge_n = 0;
    tick(1);
    check("e1_state_compute", 32'(dut.state_q), 32'd1);
    check("e1_led", 32'(bus.led), 32'h0000);

    bus.sel = 1'b1;
    #1;
`ifdef MMMAIN_TRACE_EN
    check("compute_sel1_trace", 32'(bus.led), 32'h0000);
`else
    check("compute_sel1_status", 32'(bus.led), 32'h1000);
`endif
    bus.sel = 1'b0;
    #1;

    tick(3);  // edge 4: first element not yet committed
    check("e4_led", 32'(bus.led), 32'd0);
    tick(1);  // edge 5: C[0][0] = 90
    check("e5_led", 32'(bus.led), 32'd90);
    check("e5_c00", 32'(dut.c_q[0]), 32'd90);
    tick(4);  // edge 9: 90 + 100
    check("e9_led", 32'(bus.led), 32'd190);
    tick(12); // edge 21: row 0 (420) + C[1][0] (202)
    check("e21_led", 32'(bus.led), 32'd622);
    tick(43); // edge 64: everything but C[3][3]
    check("e64_led", 32'(bus.led), 32'd4344);
    check("e64_state", 32'(dut.state_q), 32'd1);
    tick(1);  // edge 65: final
    check("e65_led", 32'(bus.led), 32'h1350);
    check("e65_state_done", 32'(dut.state_q), 32'd2);
    check("c00", 32'(dut.c_q[0]), 32'd90);
    check("c11", 32'(dut.c_q[5]), 32'd228);
    check("c22", 32'(dut.c_q[10]), 32'd398);
    check("c33", 32'(dut.c_q[15]), 32'd600);
    check("c03", 32'(dut.c_q[3]), 32'd120);
    check("c30", 32'(dut.c_q[12]), 32'd426);

    bus.sel = 1'b1;
    #1;
`ifdef MMMAIN_TRACE_EN
    check("done_sel1_trace", 32'(bus.led), 32'h0524);
    check("trace_reg", 32'(dut.trace_q), 32'd1316);
`else
    check("done_sel1_status", 32'(bus.led), 32'hA000);
`endif
    bus.sel = 1'b0;
    #1;
    tick(10);
    check("done_hold_led", 32'(bus.led), 32'h1350);

    // Second run, interrupted by a reset pulse at edge 30.
    rst = 1'b1;
    tick(1);
    rst    = 1'b0;
    edge_n = 0;
    tick(29);
    check("r2_e29_led", 32'(bus.led), 32'd1104);
    rst = 1'b1;
    tick(1);  // edge 30: reset wins over the MAC update
    check("pulse_led", 32'(bus.led), 32'h0000);
    check("pulse_state", 32'(dut.state_q), 32'd0);
    tick(1);  // edge 31: last edge with reset high
    rst    = 1'b0;
    edge_n = 0;
    tick(1);
    check("r3_e1_state", 32'(dut.state_q), 32'd1);
    check("r3_e1_led", 32'(bus.led), 32'h0000);
    tick(63); // edge 64
    check("r3_e64_led", 32'(bus.led), 32'd4344);
    tick(1);  // edge 65
    check("r3_e65_led", 32'(bus.led), 32'h1350);
    check("r3_e65_state", 32'(dut.state_q), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/mmmain_core.md
# mmmain_core

Self-contained 4×4 matrix-multiply engine with LED readout, used as the top of the matrix-multiply lab board build. After reset it computes C = A × B from two fixed on-chip 8-bit matrices using one multiply-accumulate per clock. It keeps the result matrix, a running checksum and a trace, and drives a 16-bit LED bus selected by a single switch.

## Interface
- No parameters. Matrix size is fixed at 4×4 and element width at 8 bits unsigned.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset; synchronous, active-high.
- `sel`  in  1  LED view select; may change at any time.
- `led`  out  16  display bus; combinational from registered state.

## Operation
- **Constant ROMs.**
  - A[i][j] = 4i + j + 1, giving rows 1..4, 5..8, 9..12, 13..16.
  - B equals A.
  - Both are unsigned 8-bit.
- **Result storage.** C is a 16-entry × 18-bit register array. An element is at most 4·255·255, which fits in 18 bits.
- **FSM states.** IDLE, COMPUTE, DONE, encoded 2'b00, 2'b01, 2'b10.
  - IDLE: one cycle, then COMPUTE.
  - COMPUTE: loop counters i (row), j (column), k (inner), each 2 bits, with k innermost and i outermost.
  - Each COMPUTE cycle: product p = A[i][k]·B[k][j] (16 bits).
    - If k≠3: acc ← acc + p.
    - If k=3: C[4i+j] ← acc + p; checksum ← checksum + acc + p; acc ← 0.
    - If k=3 and i=j, also trace ← trace + acc + p.
    - Counters then advance.
  - COMPUTE lasts exactly 64 cycles. The cycle with i=j=k=3 moves the FSM to DONE.
  - DONE: holds all values until reset; `done` = 1.
- **Register widths.**
  - acc: 18 bits.
  - checksum: 24 bits, running.
  - trace: 24 bits.
- **LED mapping, macro absent.**
  - `sel`=0: led = checksum[15:0]. This updates live during COMPUTE and is final in DONE.
  - `sel`=1: led = {done, 1'b0, state[1:0], 4'b0, checksum[23:16]}.
- **Reset.** Clears state, counters, acc, checksum, trace and every C entry to 0, so `led` = 16'h0000 with `sel`=0.
  - Reset asserted mid-COMPUTE aborts the run and restarts from IDLE once released.
  - Reset wins over any update in the same cycle.

## Timing
- Edge numbering: edge 0 is the last rising edge with `rst`=1. Edge n is the n-th edge after that.
- Edge 1: IDLE→COMPUTE.
- Edges 2..65: the 64 MAC cycles.
  - The first completed element, C[0][0] = 90, is written at edge 5.
  - The checksum steps once every 4 cycles.
- Edge 65: last MAC, FSM enters DONE. From then on `done`=1 and checksum = 4944 (16'h1350).
- Latency from reset release to final result: 65 clocks.
- `led` follows `sel` in the same cycle; there is no register on the select path.

## Configuration
- `MMMAIN_TRACE_EN` defined:
  - `sel`=1 shows trace[15:0] when done=1, otherwise 16'h0000.
  - The trace register and its update logic are present.
- `MMMAIN_TRACE_EN` undefined:
  - The trace register is removed.
  - `sel`=1 shows the status word described under Operation.
- The `sel`=0 view is identical in both builds.

## Test plan
- Reset held for 5 cycles, `sel`=0 → `led`=16'h0000, state IDLE. Release reset → state COMPUTE after edge 1.
- Free run with `sel`=0 → checksum 90 after edge 5, then `led`=16'h1350 (4944) from edge 65 onward.
- In DONE, C must read C[0][0]=90, C[1][1]=228, C[2][2]=398, C[3][3]=600.
- Macro absent, `sel`=1:
  - During COMPUTE → `led`=16'h1000 (state 01, done 0, high checksum 0).
  - After DONE → `led`=16'hA000 (done 1, state 10, high checksum 0).
- Macro defined, `sel`=1:
  - Before done → `led`=16'h0000.
  - After DONE → `led`=1316 (16'h0524).
- Reset pulse at edge 30 for 2 cycles, then release → run restarts. `led` reads 0, then reaches 16'h1350 exactly 65 edges after release.
